// File: rtl/i2s_pkg.sv
// Shared types for the I2S receive controller: FSM states, channel tags and
// the stereo frame layout.
package i2s_pkg;

  localparam int unsigned DEF_AUDIO_WORD_LEN = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } rx_ctrl_state_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_t;

  typedef struct packed {
    logic [DEF_AUDIO_WORD_LEN-1:0] left;
    logic [DEF_AUDIO_WORD_LEN-1:0] right;
  } stereo_frame_t;

  // LRCLK low marks the left channel, high marks the right channel.
  function automatic chan_t lrclk_to_chan(input logic lrclk);
    return lrclk ? CH_RIGHT : CH_LEFT;
  endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// First-word fall-through FIFO for stereo frames. A push while full is taken
// only when a pop happens in the same cycle; otherwise it is ignored here.
module i2s_frame_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_en;
  logic             w_rd_en;

  // Extra wrap bit separates full from empty when the indices coincide.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd_en = pop_i && !w_empty;
  assign w_wr_en = push_i && (!w_full || w_rd_en);

  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign data_o  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage; on full+pop the write lands in the slot just vacated by the head.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/i2s_rx_ctrl.sv
// I2S receive controller: sequences the receiver enable, drops warm-up frames,
// pairs left/right words into frames and streams them out through a FIFO.
module i2s_rx_ctrl
  import i2s_pkg::*;
#(
  parameter int unsigned AUDIO_WORD_LEN = DEF_AUDIO_WORD_LEN,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned WARMUP_FRAMES  = 2,
  parameter int unsigned DROP_CNT_W     = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      clr_overflow_i,
  output logic                      rx_enable_o,
  input  logic                      rx_sample_i,
  input  logic [AUDIO_WORD_LEN-1:0] rx_data_i,
  input  logic                      rx_lrclk_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [AUDIO_WORD_LEN-1:0] out_left_o,
  output logic [AUDIO_WORD_LEN-1:0] out_right_o,
  output logic                      busy_o,
  output logic                      overflow_o,
  output logic [DROP_CNT_W-1:0]     drop_cnt_o
);

  localparam int unsigned FW   = 2 * AUDIO_WORD_LEN;
  localparam int unsigned WU_W = (WARMUP_FRAMES > 0) ? $clog2(WARMUP_FRAMES + 1) : 1;
  localparam logic [WU_W-1:0]       WU_LOAD  = WU_W'(WARMUP_FRAMES);
  localparam logic [WU_W-1:0]       WU_ONE   = WU_W'(1);
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;
  localparam rx_ctrl_state_t START_STATE = (WARMUP_FRAMES == 0) ? RUN : WARMUP;

  rx_ctrl_state_t            r_state;
  rx_ctrl_state_t            w_state_nxt;
  logic                      r_rx_enable;
  logic                      r_pending;
  logic [AUDIO_WORD_LEN-1:0] r_pending_left;
  logic [WU_W-1:0]           r_wu_cnt;
  logic                      r_overflow;
  logic [DROP_CNT_W-1:0]     r_drop_cnt;

  chan_t                     w_chan;
  logic                      w_sample;
  logic                      w_left_word;
  logic                      w_frame_done;
  logic                      w_start;
  logic                      w_stop;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_drop;
  logic                      w_full;
  logic                      w_empty;
  logic [FW-1:0]             w_fifo_din;
  logic [FW-1:0]             w_fifo_dout;

  assign w_chan       = lrclk_to_chan(rx_lrclk_i);
  assign w_sample     = r_rx_enable && rx_sample_i;
  assign w_left_word  = w_sample && (w_chan == CH_LEFT);
  assign w_frame_done = w_sample && (w_chan == CH_RIGHT) && r_pending;
  assign w_start      = (r_state == IDLE) && start_i;
  assign w_stop       = ((r_state == WARMUP) || (r_state == RUN)) && stop_i;
  // A frame completing alongside stop is still pushed: r_state is still RUN.
  assign w_push       = w_frame_done && (r_state == RUN);
  assign w_pop        = !w_empty && out_ready_i;
  assign w_drop       = w_push && w_full && !w_pop;
  assign w_fifo_din   = {r_pending_left, rx_data_i};

  i2s_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_fifo_din),
    .data_o  (w_fifo_dout),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Next-state logic for the capture sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) w_state_nxt = START_STATE;
        else         w_state_nxt = IDLE;
      end
      WARMUP: begin
        if (stop_i)                                  w_state_nxt = DRAIN;
        else if (w_frame_done && (r_wu_cnt == WU_ONE)) w_state_nxt = RUN;
        else                                         w_state_nxt = WARMUP;
      end
      RUN: begin
        if (stop_i) w_state_nxt = DRAIN;
        else        w_state_nxt = RUN;
      end
      DRAIN: begin
        if (w_empty) w_state_nxt = IDLE;
        else         w_state_nxt = DRAIN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, receiver enable, left/right pairing and warm-up countdown.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= IDLE;
      r_rx_enable    <= 1'b0;
      r_pending      <= 1'b0;
      r_pending_left <= '0;
      r_wu_cnt       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_rx_enable <= 1'b1;
        r_pending   <= 1'b0;
        r_wu_cnt    <= WU_LOAD;
      end else if (w_stop) begin
        r_rx_enable <= 1'b0;
        r_pending   <= 1'b0;
      end else begin
        // A second left word simply replaces the first (resynchronisation).
        if (w_left_word) begin
          r_pending_left <= rx_data_i;
          r_pending      <= 1'b1;
        end else if (w_frame_done) begin
          r_pending <= 1'b0;
        end
        if ((r_state == WARMUP) && w_frame_done) begin
          r_wu_cnt <= r_wu_cnt - WU_ONE;
        end
      end
    end
  end

  // Overflow accounting; a drop outranks a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_overflow_i)            r_drop_cnt <= DROP_ONE;
      else if (r_drop_cnt != DROP_MAX) r_drop_cnt <= r_drop_cnt + DROP_ONE;
      else                           r_drop_cnt <= r_drop_cnt;
    end else if (clr_overflow_i) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_overflow <= r_overflow;
      r_drop_cnt <= r_drop_cnt;
    end
  end

  assign rx_enable_o = r_rx_enable;
  assign busy_o      = (r_state != IDLE);
  assign overflow_o  = r_overflow;
  assign drop_cnt_o  = r_drop_cnt;
  assign out_valid_o = !w_empty;
  assign out_left_o  = w_fifo_dout[FW-1:AUDIO_WORD_LEN];
  assign out_right_o = w_fifo_dout[AUDIO_WORD_LEN-1:0];

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Directed self-checking bench for i2s_rx_ctrl with default parameters
// (24-bit words, 4-frame FIFO, 2 warm-up frames, 8-bit drop counter).
module tb_i2s_rx_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i, stop_i, clr_overflow_i;
  logic        rx_enable_o;
  logic        rx_sample_i;
  logic [23:0] rx_data_i;
  logic        rx_lrclk_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [23:0] out_left_o, out_right_o;
  logic        busy_o, overflow_o;
  logic [7:0]  drop_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  i2s_rx_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .clr_overflow_i (clr_overflow_i),
    .rx_enable_o    (rx_enable_o),
    .rx_sample_i    (rx_sample_i),
    .rx_data_i      (rx_data_i),
    .rx_lrclk_i     (rx_lrclk_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_left_o     (out_left_o),
    .out_right_o    (out_right_o),
    .busy_o         (busy_o),
    .overflow_o     (overflow_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_word(input logic lr, input logic [23:0] data);
    rx_sample_i = 1'b1;
    rx_lrclk_i  = lr;
    rx_data_i   = data;
    tick();
    rx_sample_i = 1'b0;
    rx_data_i   = 24'h0;
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_word(1'b0, l);
    send_word(1'b1, r);
  endtask

  task automatic expect_pop(input string tag, input logic [23:0] l, input logic [23:0] r);
    chk({tag, "_valid"}, out_valid_o, 1'b1);
    chk({tag, "_left"},  out_left_o,  l);
    chk({tag, "_right"}, out_right_o, r);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; stop_i = 1'b0; clr_overflow_i = 1'b0;
    rx_sample_i = 1'b0; rx_data_i = 24'h0; rx_lrclk_i = 1'b0; out_ready_i = 1'b0;
    tick(); tick();
    chk("rst_enable",   rx_enable_o, 1'b0);
    chk("rst_valid",    out_valid_o, 1'b0);
    chk("rst_left",     out_left_o,  24'h0);
    chk("rst_right",    out_right_o, 24'h0);
    chk("rst_busy",     busy_o,      1'b0);
    chk("rst_overflow", overflow_o,  1'b0);
    chk("rst_drop",     drop_cnt_o,  8'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // 1: two warm-up frames discarded, third appears one cycle after R.
    out_ready_i = 1'b1;
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("t1_enable", rx_enable_o, 1'b1);
    chk("t1_busy",   busy_o,      1'b1);
    send_frame(24'h000001, 24'h000002);
    chk("t1_wu1_valid", out_valid_o, 1'b0);
    send_frame(24'h000003, 24'h000004);
    chk("t1_wu2_valid", out_valid_o, 1'b0);
    send_frame(24'h000005, 24'h000006);
    chk("t1_valid", out_valid_o, 1'b1);
    chk("t1_left",  out_left_o,  24'h000005);
    chk("t1_right", out_right_o, 24'h000006);

    // 2: orphan right discarded, second left overwrites the first.
    send_word(1'b1, 24'hAAAAAA);
    chk("t2_orphan_valid", out_valid_o, 1'b0);
    send_word(1'b0, 24'h111111);
    send_word(1'b0, 24'h222222);
    send_word(1'b1, 24'h333333);
    chk("t2_valid", out_valid_o, 1'b1);
    chk("t2_left",  out_left_o,  24'h222222);
    chk("t2_right", out_right_o, 24'h333333);
    tick();
    chk("t2_single", out_valid_o, 1'b0);
    out_ready_i = 1'b0;

    // 3: six frames into a four-deep FIFO with no consumer.
    for (int i = 0; i < 6; i++) begin
      send_frame(24'h000100 + 24'(i), 24'h000200 + 24'(i));
      if (i == 3) chk("t3_no_ovf_at_full", overflow_o, 1'b0);
    end
    chk("t3_overflow", overflow_o, 1'b1);
    chk("t3_drop",     drop_cnt_o, 8'd2);
    chk("t3_head_l",   out_left_o, 24'h000100);
    clr_overflow_i = 1'b1; tick(); clr_overflow_i = 1'b0;
    chk("t3_clr_ovf",  overflow_o, 1'b0);
    chk("t3_clr_drop", drop_cnt_o, 8'd0);
    chk("t3_clr_valid", out_valid_o, 1'b1);
    chk("t3_clr_head", out_right_o, 24'h000200);

    // 4: full FIFO, pop in the same cycle as a push -> no drop.
    send_word(1'b0, 24'h000106);
    out_ready_i = 1'b1;
    send_word(1'b1, 24'h000206);
    out_ready_i = 1'b0;
    chk("t4_ovf",   overflow_o, 1'b0);
    chk("t4_drop",  drop_cnt_o, 8'd0);
    chk("t4_head",  out_left_o, 24'h000101);
    send_frame(24'h000107, 24'h000207);
    chk("t4_still_full_ovf",  overflow_o, 1'b1);
    chk("t4_still_full_drop", drop_cnt_o, 8'd1);
    send_word(1'b0, 24'h000108);
    clr_overflow_i = 1'b1;
    send_word(1'b1, 24'h000208);
    clr_overflow_i = 1'b0;
    chk("t4_drop_vs_clr_ovf",  overflow_o, 1'b1);
    chk("t4_drop_vs_clr_drop", drop_cnt_o, 8'd1);
    clr_overflow_i = 1'b1; tick(); clr_overflow_i = 1'b0;
    chk("t4_clr_drop", drop_cnt_o, 8'd0);
    expect_pop("t4_p0", 24'h000101, 24'h000201);
    expect_pop("t4_p1", 24'h000102, 24'h000202);
    expect_pop("t4_p2", 24'h000103, 24'h000203);
    expect_pop("t4_p3", 24'h000106, 24'h000206);
    chk("t4_empty", out_valid_o, 1'b0);

    // 5: stop with three frames buffered, then drain.
    for (int i = 0; i < 3; i++) send_frame(24'h000300 + 24'(i), 24'h000400 + 24'(i));
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    chk("t5_enable", rx_enable_o, 1'b0);
    chk("t5_busy",   busy_o,      1'b1);
    send_frame(24'h00DEAD, 24'h00BEEF);
    expect_pop("t5_p0", 24'h000300, 24'h000400);
    expect_pop("t5_p1", 24'h000301, 24'h000401);
    expect_pop("t5_p2", 24'h000302, 24'h000402);
    chk("t5_empty", out_valid_o, 1'b0);
    tick();
    chk("t5_idle", busy_o, 1'b0);

    // 6: asynchronous reset in RUN with two frames buffered.
    start_i = 1'b1; tick(); start_i = 1'b0;
    send_frame(24'h000001, 24'h000002);
    send_frame(24'h000003, 24'h000004);
    send_frame(24'h000500, 24'h000600);
    send_frame(24'h000501, 24'h000601);
    chk("t6_pre_valid", out_valid_o, 1'b1);
    @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    chk("t6_async_valid",  out_valid_o, 1'b0);
    chk("t6_async_enable", rx_enable_o, 1'b0);
    chk("t6_async_busy",   busy_o,      1'b0);
    #2 rst_ni = 1'b1;
    send_frame(24'h000700, 24'h000800);
    tick();
    chk("t6_post_valid",  out_valid_o, 1'b0);
    chk("t6_post_busy",   busy_o,      1'b0);
    chk("t6_post_enable", rx_enable_o, 1'b0);
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("t6_restart_enable", rx_enable_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
